// File: rtl/mmm_top.sv
// 2x2 posit<4,0> matrix multiply by outer-product accumulation with exact fixed-point
// accumulators, round-to-nearest-even posit output and a two-row output drain.
module mmm_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [17:0] data_i,
  output logic        valid_o,
  output logic [7:0]  data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW0 = 2'd1,
    S_ROW1 = 2'd2
  } state_e;

  state_e             state_q;
  logic signed [15:0] acc_q [4];
  logic signed [15:0] acc_d [4];
  logic [3:0]         nar_q;
  logic [3:0]         nar_d;
  logic [15:0]        buf_q;
  logic [15:0]        buf_d;
  logic               valid_q;
  logic [7:0]         data_q;

  logic [3:0]         a_enc [2];
  logic [3:0]         b_enc [2];
  logic signed [5:0]  qa;
  logic signed [5:0]  qb;
  logic signed [15:0] prod;
  logic               pnar;
  logic               beat_first;
  logic               beat_last;

  assign beat_first = data_i[16];
  assign beat_last  = data_i[17];
  assign valid_o    = valid_q;
  assign data_o     = data_q;

  // Posit<4,0> value in quarters; NaR (1000) decodes to 0 and is flagged separately.
  function automatic logic signed [5:0] decode(input logic [3:0] enc);
    logic [3:0]        mag_e;
    logic signed [5:0] q;
    mag_e = enc[3] ? (~enc + 4'd1) : enc;
    case (mag_e[2:0])
      3'd0:    q = 6'sd0;
      3'd1:    q = 6'sd1;
      3'd2:    q = 6'sd2;
      3'd3:    q = 6'sd3;
      3'd4:    q = 6'sd4;
      3'd5:    q = 6'sd6;
      3'd6:    q = 6'sd8;
      default: q = 6'sd16;
    endcase
    return enc[3] ? -q : q;
  endfunction

  function automatic logic is_nar(input logic [3:0] enc);
    return enc == 4'b1000;
  endfunction

  // Accumulator is in sixteenths; thresholds are midpoints between representable
  // magnitudes, with ties resolved toward the even encoding.
  function automatic logic [3:0] round_posit(input logic signed [15:0] x, input logic nar);
    logic [15:0] mag;
    logic [2:0]  c;
    logic [3:0]  code;
    mag = x[15] ? 16'(-x) : 16'(x);
    if (mag == 16'd0)       c = 3'd0;
    else if (mag <= 16'd5)  c = 3'd1;
    else if (mag <= 16'd10) c = 3'd2;
    else if (mag <  16'd14) c = 3'd3;
    else if (mag <= 16'd20) c = 3'd4;
    else if (mag <  16'd28) c = 3'd5;
    else if (mag <= 16'd48) c = 3'd6;
    else                    c = 3'd7;
    code = {1'b0, c};
    if (x[15]) code = ~code + 4'd1;
    return nar ? 4'b1000 : code;
  endfunction

  always_comb begin
    a_enc[0] = data_i[3:0];
    a_enc[1] = data_i[7:4];
    b_enc[0] = data_i[11:8];
    b_enc[1] = data_i[15:12];
    qa    = 6'sd0;
    qb    = 6'sd0;
    prod  = 16'sd0;
    pnar  = 1'b0;
    nar_d = nar_q;
    buf_d = 16'h0000;
    for (int n = 0; n < 4; n++) begin
      acc_d[n] = acc_q[n];
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        qa   = decode(a_enc[i]);
        qb   = decode(b_enc[j]);
        prod = 16'(qa) * 16'(qb);
        pnar = is_nar(a_enc[i]) | is_nar(b_enc[j]);
        if (valid_i) begin
          if (beat_first) begin
            acc_d[i*2+j] = prod;
            nar_d[i*2+j] = pnar;
          end else begin
            acc_d[i*2+j] = acc_q[i*2+j] + prod;
            nar_d[i*2+j] = nar_q[i*2+j] | pnar;
          end
        end
        buf_d[(i*2+j)*4 +: 4] = round_posit(acc_d[i*2+j], nar_d[i*2+j]);
      end
    end
  end

  // The snapshot is taken from the post-beat sums so a new matrix may start
  // accumulating on the very next edge while the buffer drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        acc_q[n] <= 16'sd0;
      end
      nar_q   <= 4'h0;
      buf_q   <= 16'h0000;
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      for (int n = 0; n < 4; n++) begin
        acc_q[n] <= acc_d[n];
      end
      nar_q <= nar_d;
      case (state_q)
        S_ROW0: begin
          valid_q <= 1'b1;
          data_q  <= buf_q[7:0];
          state_q <= S_ROW1;
        end
        S_ROW1: begin
          valid_q <= 1'b1;
          data_q  <= buf_q[15:8];
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          data_q  <= 8'h00;
          state_q <= S_IDLE;
        end
      endcase
      if (valid_i && beat_last) begin
        buf_q   <= buf_d;
        state_q <= S_ROW0;
      end
    end
  end

endmodule

// File: tb/tb_mmm_top.sv
// Directed bench for mmm_top: one task per scenario, each with its own
// inline comparisons against hand-computed result rows.
module tb_mmm_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [17:0] data_i = 18'h0;
  logic        valid_o;
  logic [7:0]  data_o;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic        obs_v;
  logic [7:0]  obs_d;

  always #5 clk = ~clk;

  mmm_top dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

  // Samples outputs settled from the previous rising edge, then drives the next inputs.
  task automatic step(input logic r, input logic v, input logic [17:0] d);
    @(negedge clk);
    obs_v   = valid_o;
    obs_d   = data_o;
    rst     = r;
    valid_i = v;
    data_i  = d;
  endtask

  task automatic test_reset();
    logic       ev [4];
    logic [7:0] ed [4];
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h64, 8'h00, 8'h00};
    step(1'b1, 1'b1, 18'h17777);
    step(1'b1, 1'b1, 18'h17777);
    step(1'b0, 1'b1, 18'h26404);
    vec_cnt++;
    if (obs_v !== 1'b0 || obs_d !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_state: got v=%b d=%h want v=0 d=00", obs_v, obs_d);
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 18'h0);
      vec_cnt++;
      if (obs_v !== ev[c] || obs_d !== ed[c]) begin
        err_cnt++;
        $display("FAIL reset_no_first c%0d: got v=%b d=%h want v=%b d=%h", c, obs_v, obs_d, ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_two_beat(input string name, input logic [17:0] b0, input logic [17:0] b1,
                               input logic [7:0] r0, input logic [7:0] r1);
    logic       ev [4];
    logic [7:0] ed [4];
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, r0, r1, 8'h00};
    step(1'b0, 1'b1, b0);
    step(1'b0, 1'b1, b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 18'h0);
      vec_cnt++;
      if (obs_v !== ev[c] || obs_d !== ed[c]) begin
        err_cnt++;
        $display("FAIL %s c%0d: got v=%b d=%h want v=%b d=%h", name, c, obs_v, obs_d, ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_negative();
    logic       ev [4];
    logic [7:0] ed [4];
    // A00=-1 A10=1/2, B00=3/2 B01=-3/2 in a single first+last beat.
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h5B, 8'hD3, 8'h00};
    step(1'b0, 1'b1, 18'h3B52C);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 18'h0);
      vec_cnt++;
      if (obs_v !== ev[c] || obs_d !== ed[c]) begin
        err_cnt++;
        $display("FAIL negative c%0d: got v=%b d=%h want v=%b d=%h", c, obs_v, obs_d, ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_gap();
    logic       ev [4];
    logic [7:0] ed [4];
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h76, 8'h00, 8'h00};
    step(1'b0, 1'b1, 18'h16404);
    step(1'b0, 1'b0, 18'h3FFFF);
    step(1'b0, 1'b1, 18'h06404);
    step(1'b0, 1'b1, 18'h20000);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 18'h0);
      vec_cnt++;
      if (obs_v !== ev[c] || obs_d !== ed[c]) begin
        err_cnt++;
        $display("FAIL gap c%0d: got v=%b d=%h want v=%b d=%h", c, obs_v, obs_d, ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] beats [7];
    logic        ev [7];
    logic [7:0]  ed [7];
    beats = '{18'h15544, 18'h00000, 18'h20011, 18'h0, 18'h0, 18'h0, 18'h0};
    ev    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ed    = '{8'h00, 8'h64, 8'h75, 8'h00, 8'h55, 8'h55, 8'h00};
    step(1'b0, 1'b1, 18'h16404);
    step(1'b0, 1'b1, 18'h27540);
    for (int c = 0; c < 7; c++) begin
      step(1'b0, (c < 3), beats[c]);
      vec_cnt++;
      if (obs_v !== ev[c] || obs_d !== ed[c]) begin
        err_cnt++;
        $display("FAIL back_to_back c%0d: got v=%b d=%h want v=%b d=%h", c, obs_v, obs_d, ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic       ev [4];
    logic [7:0] ed [4];
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h64, 8'h00, 8'h00};
    step(1'b0, 1'b1, 18'h17777);
    step(1'b1, 1'b0, 18'h0);
    step(1'b1, 1'b0, 18'h0);
    vec_cnt++;
    if (obs_v !== 1'b0 || obs_d !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_mid_hold: got v=%b d=%h want v=0 d=00", obs_v, obs_d);
    end
    step(1'b0, 1'b1, 18'h26404);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 18'h0);
      vec_cnt++;
      if (obs_v !== ev[c] || obs_d !== ed[c]) begin
        err_cnt++;
        $display("FAIL reset_mid c%0d: got v=%b d=%h want v=%b d=%h", c, obs_v, obs_d, ev[c], ed[c]);
      end
    end
    // Reset landing on the row-0 cycle must suppress row 1.
    step(1'b0, 1'b1, 18'h16404);
    step(1'b0, 1'b1, 18'h27540);
    step(1'b0, 1'b0, 18'h0);
    step(1'b1, 1'b0, 18'h0);
    vec_cnt++;
    if (obs_v !== 1'b1 || obs_d !== 8'h64) begin
      err_cnt++;
      $display("FAIL cancel_row0: got v=%b d=%h want v=1 d=64", obs_v, obs_d);
    end
    step(1'b0, 1'b0, 18'h0);
    vec_cnt++;
    if (obs_v !== 1'b0 || obs_d !== 8'h00) begin
      err_cnt++;
      $display("FAIL cancel_row1: got v=%b d=%h want v=0 d=00", obs_v, obs_d);
    end
    step(1'b0, 1'b0, 18'h0);
    vec_cnt++;
    if (obs_v !== 1'b0 || obs_d !== 8'h00) begin
      err_cnt++;
      $display("FAIL cancel_after: got v=%b d=%h want v=0 d=00", obs_v, obs_d);
    end
  endtask

  initial begin
    test_reset();
    test_two_beat("identity",   18'h16404, 18'h27540, 8'h64, 8'h75);
    test_two_beat("saturation", 18'h17777, 18'h27777, 8'h77, 8'h77);
    test_two_beat("tie_even",   18'h15544, 18'h25544, 8'h66, 8'h66);
    test_two_beat("minpos",     18'h11111, 18'h20000, 8'h11, 8'h11);
    test_two_beat("nar",        18'h14448, 18'h20000, 8'h88, 8'h44);
    test_negative();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
